// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  EN_ALL_OFF = 8'hFF;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous double buffering.
// Optional SEG_LZ_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_GAP   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Data,
  input  logic        Load,
  output logic [7:0]  en_out,
  output logic [6:0]  out7,
  output logic        frame_done
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankGap = CntW'(BLANK_GAP);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [31:0]     disp_q, disp_d;
  logic            pending_q, pending_d;
  logic [7:0]      en_q, en_d;
  logic [6:0]      seg_q, seg_d;
  logic            fd_q, fd_d;

  logic            slot_wrap;
  logic [3:0]      nibble;
  logic [6:0]      dec_seg;
  logic            suppress;

  assign slot_wrap = (cnt_q == CntMax);
  assign nibble    = disp_q[{idx_q, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] keep;
  always_comb begin
    keep = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      keep[k] = (k == 0) || (|(disp_q >> (4 * k)));
    end
  end
  assign suppress = ~keep[idx_q];
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = slot_wrap ? idx_q + 3'd1 : idx_q;
    fd_d      = slot_wrap && (idx_q == 3'd7);
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;

    // The boundary is the frame_done cycle; digit 0 is still blanked, so a commit here
    // is never torn. A Load on that cycle bypasses the shadow and beats any pending word.
    if (fd_q) begin
      pending_d = 1'b0;
      if (Load) begin
        disp_d = Data;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (Load) begin
      shadow_d  = Data;
      pending_d = 1'b1;
    end

    if (cnt_q < BlankGap) begin
      en_d  = EN_ALL_OFF;
      seg_d = SEG_BLANK;
    end else begin
      en_d  = ~(8'b1 << idx_q);
      seg_d = suppress ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      en_q      <= EN_ALL_OFF;
      seg_q     <= SEG_BLANK;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

  assign en_out     = en_q;
  assign out7       = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (REFRESH_DIV=8, BLANK_GAP=2).
module tb_seg_scan_driver;

  logic        Clk;
  logic        Reset;
  logic [31:0] Data;
  logic        Load;
  logic [7:0]  en_out;
  logic [6:0]  out7;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] ZERO_HI = 7'h7F;
`else
  localparam logic [6:0] ZERO_HI = 7'h40;
`endif

  seg_scan_driver #(
    .REFRESH_DIV (8),
    .BLANK_GAP   (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Data       (Data),
    .Load       (Load),
    .en_out     (en_out),
    .out7       (out7),
    .frame_done (frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    Reset = 1'b0;
    Load  = 1'b0;
    Data  = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (en_out !== 8'hFF || out7 !== 7'h7F || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d en=%h seg=%h fd=%b required FF/7F/0",
                 i, en_out, out7, frame_done);
      end
    end
    Reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (en_out !== 8'hFF || out7 !== 7'h7F) begin
        errors++;
        $display("FAIL reset_gap cyc=%0d en=%h seg=%h required FF/7F", i, en_out, out7);
      end
    end
    tick();
    checks++;
    if (en_out !== 8'hFE || out7 !== 7'h40) begin
      errors++;
      $display("FAIL first_digit en=%h seg=%h required FE/40", en_out, out7);
    end
    n = 3;
    while (frame_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL first_frame_done cycles=%0d required 64", n);
    end
  endtask

  task automatic test_scan_load();
    bit ok;
    int k;
    logic [7:0] xe;
    logic [6:0] xs;
    logic [6:0] ea [8];
    logic [6:0] eb [8];
    ea = '{7'h40, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI};
    eb = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_sync frame_done=%b required 1", frame_done); end
    for (int o = 1; o <= 64; o++) begin
      tick();
      Load = (o == 5);
      if (o == 5) Data = 32'h1234ABCD;
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = ea[k]; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL scan_old off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
    for (int o = 1; o <= 64; o++) begin
      tick();
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = eb[k]; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL scan_new off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    logic [7:0] xe;
    logic [6:0] xs;
    logic [6:0] ea [8];
    ea = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_sync frame_done=%b required 1", frame_done); end
    for (int o = 1; o <= 64; o++) begin
      tick();
      Load = (o == 3) || (o == 20);
      if (o == 3) Data = 32'h11111111;
      if (o == 20) Data = 32'h22222222;
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = ea[k]; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL b2b_hold off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
    for (int o = 1; o <= 64; o++) begin
      tick();
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = 7'h24; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL b2b_latest off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
  endtask

  task automatic test_boundary_load();
    bit ok;
    int k;
    logic [7:0] xe;
    logic [6:0] xs;
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bnd_sync frame_done=%b required 1", frame_done); end
    Load = 1'b1;
    Data = 32'hFFFFFFFF;
    for (int o = 1; o <= 64; o++) begin
      tick();
      Load = 1'b0;
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = 7'h0E; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL bnd_load off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
  endtask

  task automatic test_hex_codes();
    bit ok;
    int k;
    logic [7:0] xe;
    logic [6:0] xs;
    logic [6:0] ea [8];
    ea = '{7'h12, 7'h08, 7'h40, 7'h06, 7'h10, 7'h00, 7'h78, 7'h02};
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hex_sync frame_done=%b required 1", frame_done); end
    Load = 1'b1;
    Data = 32'h6789E0A5;
    for (int o = 1; o <= 64; o++) begin
      tick();
      Load = 1'b0;
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = ea[k]; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL hex_codes off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_sync frame_done=%b required 1", frame_done); end
    for (int o = 1; o <= 36; o++) begin
      tick();
      Load = (o == 10);
      if (o == 10) Data = 32'h33333333;
    end
    checks++;
    if (en_out !== 8'hEF || out7 !== 7'h10) begin
      errors++;
      $display("FAIL rmid_digit4 en=%h seg=%h required EF/10", en_out, out7);
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (en_out !== 8'hFF || out7 !== 7'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async en=%h seg=%h fd=%b required FF/7F/0", en_out, out7, frame_done);
    end
    tick();
    tick();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (en_out !== 8'hFF || out7 !== 7'h7F) begin
      errors++;
      $display("FAIL rmid_gap en=%h seg=%h required FF/7F", en_out, out7);
    end
    tick();
    checks++;
    if (en_out !== 8'hFE || out7 !== 7'h40) begin
      errors++;
      $display("FAIL rmid_restart en=%h seg=%h required FE/40", en_out, out7);
    end
    n = 3;
    while (frame_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL rmid_frame cycles=%0d required 64", n);
    end
    tick(); tick(); tick();
    checks++;
    if (en_out !== 8'hFE || out7 !== 7'h40) begin
      errors++;
      $display("FAIL rmid_discard d0 en=%h seg=%h required FE/40", en_out, out7);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (en_out !== 8'hFD || out7 !== ZERO_HI) begin
      errors++;
      $display("FAIL rmid_discard d1 en=%h seg=%h required FD/%h", en_out, out7, ZERO_HI);
    end
  endtask

  task automatic test_lz();
    bit ok;
    int k;
    logic [7:0] xe;
    logic [6:0] xs;
    logic [6:0] ea [8];
    logic [6:0] eb [8];
    ea = '{7'h12, 7'h08, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI};
    eb = '{7'h40, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI, ZERO_HI};
    Data = 32'h33333333;
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lz_sync frame_done=%b required 1", frame_done); end
    Load = 1'b1;
    Data = 32'h000000A5;
    for (int o = 1; o <= 64; o++) begin
      tick();
      Load = (o == 64);
      if (o == 64) Data = 32'h0;
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = ea[k]; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL lz_a5 off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
    for (int o = 1; o <= 64; o++) begin
      tick();
      Load = 1'b0;
      k = (o - 1) / 8;
      if ((o - 1) % 8 < 2) begin xe = 8'hFF; xs = 7'h7F; end
      else begin xe = ~(8'h01 << k); xs = eb[k]; end
      checks++;
      if (en_out !== xe || out7 !== xs || frame_done !== (o == 64)) begin
        errors++;
        $display("FAIL lz_zero off=%0d en=%h/%h seg=%h/%h fd=%b", o, en_out, xe, out7, xs,
                 frame_done);
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    Load  = 1'b0;
    Data  = '0;
    test_reset();
    test_scan_load();
    test_back_to_back();
    test_boundary_load();
    test_hex_codes();
    test_reset_mid();
    test_lz();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed eight-digit seven-segment scan controller; drives the `en_out`/`out7` pins of the board-level top.
- Consumes a 32-bit word from the processor datapath (register/PC/ALU result) and shows it as 8 hex digits.
- Incoming words are double-buffered and committed only at frame boundaries, so no digit ever shows a torn value.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); legal range 4..2^20.
- BLANK_GAP, 4, cycles at the start of each slot with all digits off (anti-ghosting); must be < REFRESH_DIV.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Data  in  32  value to display; digit k shows Data[4k+3:4k], digit 0 rightmost.
- Load  in  1  one-cycle strobe; capture Data into the shadow register.
- en_out  out  8  digit enables, active-low, one-hot-low while a digit is lit.
- out7  out  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse when the scan wraps digit 7 to digit 0.

Behaviour:
- Reset (Reset=0, async): en_out=8'hFF, out7=7'h7F, frame_done=0, slot counter=0, digit index=0, shadow=0, display register=0, pending=0.
- Slot counter counts 0..REFRESH_DIV-1, then wraps to 0. On the wrap cycle the digit index increments modulo 8 (7→0).
- Output timing:
  - Outputs are registered and reflect the counter/index state of the previous cycle (1-cycle latency).
  - Counter < BLANK_GAP: en_out=8'hFF, out7=7'h7F.
  - Otherwise: en_out=~(8'b1<<index), out7=hex code of display nibble[index].
- Hex codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit).
- Load (not on a frame boundary): shadow<=Data, pending<=1. Back-to-back Loads overwrite: latest value wins.
- Frame boundary (index 7 → 0):
  - frame_done pulses high for exactly one cycle, registered, coincident with the first cycle of digit 0's slot.
  - If pending: display register<=shadow, pending<=0.
- Load on the boundary cycle itself: Data goes directly to the display register, pending stays 0.
- No Load ever: the display register holds its value indefinitely.
- Reset asserted mid-scan: immediate blank outputs; scan restarts at digit 0, counter 0 after release. Any pending value is discarded.
- Counter width: ceil(log2(REFRESH_DIV)) bits; no other arithmetic.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. Any digit above the highest nonzero nibble of the display register shows out7=7'h7F, with its enable still asserted normally. Digit 0 is never suppressed, so a value of 0 shows a single "0". The suppression mask is computed from the display register, not the shadow.
- Undefined: all 8 digits are always shown, zeros included.

Decomposition:
- Shared package/include seg_pkg:
  - SEG_BLANK=7'h7F and the 16 hex segment constants.
  - EN_ALL_OFF=8'hFF.
  - NUM_DIGITS=8.
- Sub-module hex7seg_dec: purely combinational nibble→out7 decode, instantiated once on the muxed nibble.
- Scan counter, index, buffering and output registers live in seg_scan_driver.

Test Plan (REFRESH_DIV=8, BLANK_GAP=2):
- Reset held low 10 cycles, then released → en_out=FF, out7=7F throughout reset. First lit digit 0 appears 3 cycles after release, with en_out=FE.
- Load Data=32'h1234ABCD at cycle 5 → shown only from the next frame_done. Digits 0..7 read d,C,b,A,4,3,2,1 (out7=21,46,03,08,19,30,24,79). Each lit for 6 of 8 cycles; blank for 2 cycles.
- Two Loads (32'h11111111, then 32'h22222222) in the same frame → next frame shows all "2" (24); 11111111 is never displayed.
- Load coinciding with the frame_done cycle, Data=32'hFFFFFFFF → displayed in that same frame (all out7=0E); pending stays 0.
- Reset pulsed low during digit 4 → en_out=FF immediately, asynchronously. After release, the scan restarts at digit 0 with display value 0.
- SEG_LZ_BLANK_EN defined, Load 32'h000000A5 → digits 0,1 show 12,08; digits 2..7 show 7F. Load 0 → only digit 0 shows 40.
